// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy/state
// encoding and the saturating-increment helper used by performance counters.
package pipe_pkg;

    // State value equals the number of held entries, so it doubles as occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // Increment value by one, clamping at 2^width-1 so the result never wraps.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_v;
        max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (value >= max_v) ? max_v : value + 64'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// CNT_W-bit saturating up-counter with synchronous clear; the clear wins over
// an increment in the same cycle.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = CNT_W'(sat_inc(64'(count_q), CNT_W));
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage pipeline register with a 2-entry skid buffer. The main
// entry is the head and drives out_*; the skid entry catches the one payload
// accepted while downstream stalls, which lets in_ready come from a flop.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W             = 128,
    parameter int CTRL_W             = 8,
    parameter int ZERO_DATA_ON_FLUSH = 1,
    parameter int CNT_W              = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_d,     state_q;
    logic              in_ready_d,  in_ready_q;
    logic              out_valid_d, out_valid_q;
    logic [DATA_W-1:0] main_data_d, main_data_q;
    logic [CTRL_W-1:0] main_ctrl_d, main_ctrl_q;
    logic [DATA_W-1:0] skid_data_d, skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_d, skid_ctrl_q;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next state and storage moves; flush overrides any transfer this cycle.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (ZERO_DATA_ON_FLUSH != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = TWO;
                    end else if (out_fire) begin
                        state_d     = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Handshake flags are precomputed from the next occupancy.
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    // Registers; reset clears control and payload alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    // Back-pressure counter: counts cycles the head is offered but refused.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (out_valid_q & ~out_ready),
        .count (stall_cnt)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances (zeroing flush with a 4-bit stall
// counter, retaining flush with a 16-bit counter) share one stimulus stream
// and are compared each cycle against a queue-based model of the stage.
module tb_pipe_stage_skid;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic [7:0]   in_ctrl;
    logic         flush;
    logic         out_ready;

    logic         in_ready_a,  in_ready_b;
    logic         out_valid_a, out_valid_b;
    logic [127:0] out_data_a;
    logic [31:0]  out_data_b;
    logic [7:0]   out_ctrl_a,  out_ctrl_b;
    logic [1:0]   occ_a,       occ_b;
    logic [3:0]   stall_a;
    logic [15:0]  stall_b;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W(128), .CTRL_W(8), .ZERO_DATA_ON_FLUSH(1), .CNT_W(4)
    ) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_ctrl(out_ctrl_a), .occupancy(occ_a), .stall_cnt(stall_a)
    );

    pipe_stage_skid #(
        .DATA_W(32), .CTRL_W(8), .ZERO_DATA_ON_FLUSH(0), .CNT_W(16)
    ) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data[31:0]), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_ctrl(out_ctrl_b), .occupancy(occ_b), .stall_cnt(stall_b)
    );

    typedef struct packed {
        logic [127:0] d;
        logic [7:0]   c;
    } ent_t;

    // Reference model: FIFO contents plus what the head register shows when empty.
    ent_t         q[$];
    logic         rdy_m;
    logic [127:0] shown_a, shown_b;
    logic [7:0]   shown_c;
    int           stall_ma, stall_mb;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic r, input logic iv, input logic [127:0] d,
                        input logic [7:0] c, input logic fl, input logic ordy);
        logic in_fire_m, out_fire_m, was_valid;
        rst = r; in_valid = iv; in_data = d; in_ctrl = c; flush = fl; out_ready = ordy;
        was_valid  = (q.size() > 0);
        in_fire_m  = iv & rdy_m;
        out_fire_m = was_valid & ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            rdy_m = 1'b0;
            shown_a = '0; shown_b = '0; shown_c = '0;
            stall_ma = 0; stall_mb = 0;
        end else begin
            if (was_valid && !ordy) begin
                if (stall_ma < 15)    stall_ma++;
                if (stall_mb < 65535) stall_mb++;
            end
            if (fl) begin
                q.delete();
                shown_a = '0;
                shown_c = '0;
            end else begin
                if (out_fire_m) void'(q.pop_front());
                if (in_fire_m)  q.push_back('{d: d, c: c});
            end
            rdy_m = (q.size() < 2);
            if (q.size() > 0) begin
                shown_a = q[0].d;
                shown_b = q[0].d;
                shown_c = q[0].c;
            end
        end
        #1;
        chk("in_ready_a",  128'(in_ready_a),  128'(rdy_m));
        chk("in_ready_b",  128'(in_ready_b),  128'(rdy_m));
        chk("out_valid_a", 128'(out_valid_a), 128'(q.size() > 0));
        chk("out_valid_b", 128'(out_valid_b), 128'(q.size() > 0));
        chk("occ_a",       128'(occ_a),       128'(q.size()));
        chk("occ_b",       128'(occ_b),       128'(q.size()));
        chk("out_data_a",  out_data_a,        shown_a);
        chk("out_data_b",  128'(out_data_b),  128'(shown_b[31:0]));
        chk("out_ctrl_a",  128'(out_ctrl_a),  128'(shown_c));
        chk("out_ctrl_b",  128'(out_ctrl_b),  128'(shown_c));
        chk("stall_a",     128'(stall_a),     128'(stall_ma));
        chk("stall_b",     128'(stall_b),     128'(stall_mb));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] held_a;
        logic [31:0]  held_b;
        q.delete();
        rdy_m = 1'b0;
        shown_a = '0; shown_b = '0; shown_c = '0;
        stall_ma = 0; stall_mb = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;

        // Reset for two cycles, then stream 1..4 with downstream always ready.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 128'hDEAD, 8'h5A, 0, 1);
        chk("reset_in_ready", 128'(in_ready_a), 128'd0);
        chk("reset_occ",      128'(occ_a),      128'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("post_reset_ready", 128'(in_ready_a), 128'd1);
        for (int i = 1; i <= 4; i++) step(0, 1, 128'(i), 8'(i), 0, 1);
        chk("stream_last_data", out_data_a, 128'd4);
        step(0, 0, 0, 0, 0, 1);

        // Back-pressure: 10 and 11 are taken, 12 waits upstream.
        step(0, 1, 128'd10, 8'h10, 0, 0);
        step(0, 1, 128'd11, 8'h11, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 128'd12, 8'h12, 0, 0);
        chk("bp_ready_low", 128'(in_ready_a), 128'd0);
        chk("bp_head_10",   out_data_a,       128'd10);
        for (int i = 0; i < 4; i++) step(0, 1, 128'd12, 8'h12, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Flush while full together with an incoming payload.
        step(0, 1, rnd128(), 8'hFF, 0, 0);
        step(0, 1, rnd128(), 8'hFF, 0, 0);
        step(0, 1, 128'hBAD, 8'hFF, 1, 0);
        chk("flush_full_data_a", out_data_a, 128'd0);
        chk("flush_full_ready",  128'(in_ready_a), 128'd1);
        step(0, 0, 0, 0, 0, 1);

        // Flush coincident with an out_fire: instance b keeps its data.
        step(0, 1, 128'h1234_5678, 8'hA5, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("flush_keep_data_b", 128'(out_data_b), 128'h1234_5678);
        step(0, 0, 0, 0, 0, 1);

        // Saturation of the 4-bit counter, then reset mid-stall.
        step(0, 1, 128'h77, 8'h07, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
        chk("sat_at_15", 128'(stall_a), 128'd15);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_mid_stall", 128'(stall_b), 128'd0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 1),
                 ($urandom_range(0, 99) < 70),
                 rnd128(), 8'($urandom),
                 ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 60));
        end

        // Stability under stall with random data offered upstream.
        step(0, 1, rnd128(), 8'h3C, 0, 0);
        held_a = out_data_a;
        held_b = out_data_b;
        for (int i = 0; i < 5; i++) step(0, 1, rnd128(), 8'($urandom), 0, 0);
        chk("stable_a", out_data_a, held_a);
        chk("stable_b", 128'(out_data_b), 128'(held_b));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
